// File: rtl/pipe_ibuf.sv
// Instruction buffer between fetch and decode: a small circular FIFO of {inst, pc}
// entries with a level-held write handshake, a decode-side pop and a flush on purge.
module pipe_ibuf #(
  parameter int INST_L = 32,
  parameter int PC_L   = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_L  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_we,
  input  logic [INST_L-1:0] inst_in,
  input  logic [PC_L-1:0]   pc_in,
  output logic              buf_wack,
  output logic              buf_f,
  output logic              buf_e,
  input  logic              purge,
  input  logic              rd_re,
  output logic              rd_valid,
  output logic [INST_L-1:0] inst_out,
  output logic [PC_L-1:0]   pc_out,
  output logic [PTR_L:0]    count
);

  localparam int ENT_L = INST_L + PC_L;
  localparam logic [PTR_L:0]   FULL_C  = (PTR_L+1)'(DEPTH);
  localparam logic [PTR_L:0]   CNT_ONE = (PTR_L+1)'(1);
  localparam logic [PTR_L-1:0] PTR_ONE = PTR_L'(1);

  logic [ENT_L-1:0] mem_q [DEPTH];

  logic [PTR_L-1:0] wp_q, wp_d;
  logic [PTR_L-1:0] rp_q, rp_d;
  logic [PTR_L:0]   count_q, count_d;
  logic             armed_q, armed_d;
  logic             wack_q, wack_d;
  logic             wr_ok, rd_ok;
  logic [ENT_L-1:0] head;

  // Fullness is judged on the pre-pop count, so a full queue refuses a write even with a same-cycle pop.
  assign wr_ok = buf_we && armed_q && (count_q != FULL_C) && !purge;
  assign rd_ok = rd_re && (count_q != '0) && !purge;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    armed_d = armed_q;
    wack_d  = 1'b0;
    if (purge) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wp_d = wp_q + PTR_ONE;
      if (rd_ok) rp_d = rp_q + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      wack_d = wr_ok;
      // One accept per held request: disarm on accept, re-arm once the request drops.
      if (wr_ok)        armed_d = 1'b0;
      else if (!buf_we) armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      armed_q <= 1'b1;
      wack_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      armed_q <= armed_d;
      wack_q  <= wack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= {inst_in, pc_in};
  end

  assign head     = mem_q[rp_q];
  assign rd_valid = (count_q != '0);
  assign inst_out = rd_valid ? head[ENT_L-1:PC_L] : '0;
  assign pc_out   = rd_valid ? head[PC_L-1:0] : '0;
  assign buf_wack = wack_q;
  assign buf_f    = (count_q == FULL_C);
  assign buf_e    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_ibuf.sv
// Directed and randomized checks of pipe_ibuf against a queue-based reference model.
module tb_pipe_ibuf;
  localparam int INST_L = 32;
  localparam int PC_L   = 32;
  localparam int DEPTH  = 4;
  localparam int PTR_L  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              buf_we = 1'b0;
  logic [INST_L-1:0] inst_in = '0;
  logic [PC_L-1:0]   pc_in = '0;
  logic              purge = 1'b0;
  logic              rd_re = 1'b0;
  logic              buf_wack, buf_f, buf_e, rd_valid;
  logic [INST_L-1:0] inst_out;
  logic [PC_L-1:0]   pc_out;
  logic [PTR_L:0]    count;

  pipe_ibuf #(.INST_L(INST_L), .PC_L(PC_L), .DEPTH(DEPTH), .PTR_L(PTR_L)) dut (
    .clk(clk), .rst(rst), .buf_we(buf_we), .inst_in(inst_in), .pc_in(pc_in),
    .buf_wack(buf_wack), .buf_f(buf_f), .buf_e(buf_e), .purge(purge), .rd_re(rd_re),
    .rd_valid(rd_valid), .inst_out(inst_out), .pc_out(pc_out), .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of {inst, pc}, plus the handshake arm bit and the pending ack.
  logic [63:0] mq[$];
  bit          m_armed = 1'b1;
  bit          m_wack  = 1'b0;
  logic [31:0] got_pc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_armed = 1'b1;
    m_wack  = 1'b0;
  endtask

  task automatic model_step(input bit we, input bit re, input bit pu,
                            input logic [31:0] inst, input logic [31:0] pc);
    bit cw, cr;
    if (pu) begin
      mq.delete();
      m_wack = 1'b0;
    end else begin
      cw = we && m_armed && (mq.size() < DEPTH);
      cr = re && (mq.size() > 0);
      if (cr) void'(mq.pop_front());
      if (cw) mq.push_back({inst, pc});
      m_wack = cw;
      if (cw)       m_armed = 1'b0;
      else if (!we) m_armed = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 64'h0;
    chk({tag, ".count"},    64'(count),    64'(mq.size()));
    chk({tag, ".buf_f"},    64'(buf_f),    64'(mq.size() == DEPTH));
    chk({tag, ".buf_e"},    64'(buf_e),    64'(mq.size() == 0));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(mq.size() != 0));
    chk({tag, ".buf_wack"}, 64'(buf_wack), 64'(m_wack));
    chk({tag, ".inst_out"}, 64'(inst_out), 64'(hd[63:32]));
    chk({tag, ".pc_out"},   64'(pc_out),   64'(hd[31:0]));
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are checked 1 unit after the next edge.
  task automatic cycle(input bit we, input logic [31:0] inst, input logic [31:0] pc,
                       input bit re, input bit pu, input string tag);
    buf_we  = we;
    inst_in = inst;
    pc_in   = pc;
    rd_re   = re;
    purge   = pu;
    if (re && !pu && rd_valid) got_pc.push_back(pc_out);
    @(posedge clk);
    model_step(we, re, pu, inst, pc);
    #1;
    check_all(tag);
  endtask

  task automatic do_purge();
    cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, "purge_setup");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "purge_idle");
  endtask

  task automatic put(input logic [31:0] inst, input logic [31:0] pc, input string tag);
    cycle(1'b1, inst, pc, 1'b0, 1'b0, tag);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int nw;
    bit rwe, rre, rpu;

    // Reset state, checked while rst is high and before any clock edge.
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write held for three cycles: exactly one ack.
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, "single");
      if (buf_wack) nw++;
    end
    chk("single.wack_pulses", 64'(nw), 64'd1);
    chk("single.count", 64'(count), 64'd1);
    chk("single.inst_out", 64'(inst_out), 64'h00500093);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "single_drop");

    // Fill to DEPTH, hold a fifth request, then free one slot.
    do_purge();
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(i), 32'(i * 4), "fill");
    cycle(1'b1, 32'h104, 32'h10, 1'b0, 1'b0, "fill_held");
    cycle(1'b1, 32'h104, 32'h10, 1'b0, 1'b0, "fill_held");
    chk("fill.buf_f", 64'(buf_f), 64'd1);
    chk("fill.count", 64'(count), 64'd4);
    chk("fill.no_wack", 64'(buf_wack), 64'd0);
    cycle(1'b1, 32'h104, 32'h10, 1'b1, 1'b0, "fill_pop");
    chk("fill_pop.count", 64'(count), 64'd3);
    chk("fill_pop.no_wack", 64'(buf_wack), 64'd0);
    cycle(1'b1, 32'h104, 32'h10, 1'b0, 1'b0, "fill_fifth");
    chk("fill_fifth.wack", 64'(buf_wack), 64'd1);
    chk("fill_fifth.count", 64'(count), 64'd4);
    chk("fill_fifth.pc_out", 64'(pc_out), 64'h4);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "fill_drop");

    // Simultaneous accepted write and pop at count 2.
    do_purge();
    put(32'h200, 32'h20, "simul_setup");
    put(32'h201, 32'h24, "simul_setup");
    cycle(1'b1, 32'h202, 32'h28, 1'b1, 1'b0, "simul");
    chk("simul.count", 64'(count), 64'd2);
    chk("simul.pc_out", 64'(pc_out), 64'h24);
    chk("simul.wack", 64'(buf_wack), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "simul_drop");

    // Purge at count 3 with write and pop requests in the same cycle.
    do_purge();
    for (int i = 0; i < 3; i++) put(32'h300 + 32'(i), 32'h30 + 32'(i * 4), "purge3_setup");
    cycle(1'b1, 32'h3FF, 32'h3C, 1'b1, 1'b1, "purge3");
    chk("purge3.count", 64'(count), 64'd0);
    chk("purge3.buf_e", 64'(buf_e), 64'd1);
    chk("purge3.no_wack", 64'(buf_wack), 64'd0);
    chk("purge3.inst_out", 64'(inst_out), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "purge3_drop");

    // Wrap-around: ten writes and ten pops interleaved.
    do_purge();
    got_pc.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h500 + 32'(i), 32'(i * 4), (i >= 2), 1'b0, "wrap");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "wrap");
    end
    for (int k = 0; k < 10; k++) begin
      if (rd_valid) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "wrap_drain");
    end
    chk("wrap.pops", 64'(got_pc.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got_pc.size()) chk("wrap.order", 64'(got_pc[i]), 64'(i * 4));
    end

    // Asynchronous reset between edges at count 2, with a write held through reset.
    put(32'h600, 32'h60, "arst_setup");
    put(32'h601, 32'h64, "arst_setup");
    chk("arst_setup.count", 64'(count), 64'd2);
    #2;
    buf_we  = 1'b1;
    inst_in = 32'h700;
    pc_in   = 32'h80;
    rst     = 1'b1;
    #1;
    model_reset();
    chk("arst.buf_e", 64'(buf_e), 64'd1);
    chk("arst.rd_valid", 64'(rd_valid), 64'd0);
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_held");
    rst = 1'b0;
    cycle(1'b1, 32'h700, 32'h80, 1'b0, 1'b0, "arst_release");
    chk("arst_release.wack", 64'(buf_wack), 64'd1);
    chk("arst_release.pc_out", 64'(pc_out), 64'h80);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "arst_drop");

    // Randomized traffic; purge is only raised alongside a held write request.
    for (int i = 0; i < 400; i++) begin
      rwe = ($urandom_range(99) < 65);
      rre = ($urandom_range(99) < 45);
      rpu = rwe && ($urandom_range(99) < 4);
      cycle(rwe, $urandom, $urandom, rre, rpu, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ibuf.md
PIPE_IBUF -- requirements
Module: pipe_ibuf

Interface
REQ-001 SHALL have parameter INST_L, default 32, instruction width.
REQ-002 SHALL have parameter PC_L, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-004 SHALL have parameter PTR_L, default 2, log2(DEPTH).
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port buf_we, input, 1, fetch write request; a level held until acknowledged.
REQ-008 SHALL have port inst_in, input, INST_L, instruction to enqueue.
REQ-009 SHALL have port pc_in, input, PC_L, PC of inst_in.
REQ-010 SHALL have port buf_wack, output, 1, one-cycle write-accept pulse.
REQ-011 SHALL have port buf_f, output, 1, queue full.
REQ-012 SHALL have port buf_e, output, 1, queue empty.
REQ-013 SHALL have port purge, input, 1, flush on jump or mispredict.
REQ-014 SHALL have port rd_re, input, 1, decode pop request.
REQ-015 SHALL have port rd_valid, output, 1, head entry valid.
REQ-016 SHALL have port inst_out, output, INST_L, head instruction.
REQ-017 SHALL have port pc_out, output, PC_L, head PC.
REQ-018 SHALL have port count, output, PTR_L+1, occupied entries.

Function
REQ-019 SHALL implement a circular FIFO with write pointer wp, read pointer rp and count.
- Pointers wrap modulo DEPTH.
- count ranges 0..DEPTH.
REQ-020 SHALL keep an internal flag armed, set to 1 on reset.
REQ-021 SHALL accept a write in a cycle only when all of these hold:
- buf_we=1
- armed=1
- count<DEPTH, evaluated before any same-cycle pop
- purge=0
REQ-022 SHALL, on an accepted write, do all of the following:
- store {inst_in, pc_in} at wp
- increment wp
- assert buf_wack for exactly the next cycle
- clear armed
REQ-023 SHALL set armed again in any cycle where buf_we=0.
- Consequence: a held buf_we produces exactly one write and one buf_wack.
REQ-024 SHALL drive buf_wack registered; it SHALL never be high for two consecutive cycles.
REQ-025 SHALL drive rd_valid = (count!=0) combinationally from registered state.
REQ-026 SHALL drive inst_out and pc_out from the entry at rp when rd_valid=1, and all-zero otherwise.
REQ-027 SHALL pop when rd_re=1 and rd_valid=1 and purge=0: increment rp.
- rd_re with rd_valid=0 SHALL be ignored.
REQ-028 SHALL leave count unchanged on a simultaneous accepted write and pop.
- Otherwise count is +1 on a write and -1 on a pop.
REQ-029 SHALL drive buf_f = (count==DEPTH) and buf_e = (count==0), both from registers.
REQ-030 SHALL, on purge=1, at the next edge:
- set wp=rp=0 and count=0
- block any write and any pop in that cycle
- not assert buf_wack
- leave armed unchanged
REQ-031 SHALL accept a buf_we still held after purge in a later cycle per REQ-021.
REQ-032 SHALL leave storage contents unspecified after purge or reset; outputs are masked by REQ-026.
REQ-033 SHALL accept the write when full with a same-cycle pop? No: full blocks the write.
- The write is taken on the following cycle if buf_we is still held and armed=1.

Reset
REQ-034 SHALL, while rst=1, force all of the following regardless of clk:
- wp=0, rp=0, count=0, armed=1
- buf_wack=0, buf_f=0, buf_e=1
- rd_valid=0, inst_out=0, pc_out=0
REQ-035 SHALL, on reset mid-handshake, discard pending state; a buf_we held through reset is accepted on the first edge after release.

Verification
REQ-036 SHALL verify single write:
- stimulus: buf_we=1, inst_in=0x00500093, pc_in=0x0, held for 3 cycles
- response: one buf_wack pulse; count=1; rd_valid=1; inst_out=0x00500093; pc_out=0x0
REQ-037 SHALL verify fill:
- stimulus: 4 handshaked writes with pc 0x0, 0x4, 0x8, 0xC and a 5th buf_we held
- response: buf_f=1; count=4; no 5th buf_wack
- then rd_re for 1 cycle: 5th write accepted the following cycle; pc_out=0x4
REQ-038 SHALL verify simultaneous write and pop:
- stimulus: count=2, accepted write and rd_re in the same cycle
- response: count stays 2; head advances
REQ-039 SHALL verify purge:
- stimulus: count=3, purge with buf_we and rd_re high in the same cycle
- response: count=0, buf_e=1, no buf_wack that cycle, inst_out=0
REQ-040 SHALL verify wrap-around:
- stimulus: 10 writes and 10 pops interleaved
- response: pc_out sequence 0x0..0x24 in order; no loss or duplication
REQ-041 SHALL verify asynchronous reset:
- stimulus: rst asserted between clock edges with count=2
- response: buf_e=1, rd_valid=0 immediately
